// File: rtl/tsmp_fifo_read_scheduler.sv
// -----------------------------------------------------------------------------
// tsmp_fifo_read_scheduler
//   Drains the show-ahead TSMP packet FIFO and sequences whole packets to the
//   host-facing transmit port. A packet is started only when downstream is
//   ready. A minimum inter-packet gap is enforced. Stray body/tail words are
//   dropped to resynchronise. Over-length packets are cut with a forced tail.
//   Completed packets are counted.
//
// Ports
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   iv_fifo_rdata   FIFO head word: [133:132] tag (01 head, 10 tail, 11 body)
//   i_fifo_empty    FIFO empty flag
//   o_fifo_rd       FIFO pop (combinational)
//   i_port_ready    downstream can take a whole packet (sampled at head only)
//   ov_data         forwarded word, one cycle after its pop
//   o_data_wr       ov_data valid
//   ov_pkt_cnt      packets completed with a genuine tail (wraps)
//   o_err_pulse     one-cycle pulse per framing or length error
// -----------------------------------------------------------------------------
module tsmp_fifo_read_scheduler #(
    parameter int unsigned IFG_CYCLES     = 12,
    parameter int unsigned MAX_PKT_CYCLES = 128
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [133:0] iv_fifo_rdata,
    input  logic         i_fifo_empty,
    output logic         o_fifo_rd,
    input  logic         i_port_ready,
    output logic [133:0] ov_data,
    output logic         o_data_wr,
    output logic [15:0]  ov_pkt_cnt,
    output logic         o_err_pulse
);

    localparam logic [1:0] TAG_HEAD = 2'b01;
    localparam logic [1:0] TAG_TAIL = 2'b10;

    localparam logic [7:0] LP_LAST_WORD = 8'(MAX_PKT_CYCLES - 1);
    localparam logic [7:0] LP_GAP_LAST  = 8'(IFG_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE_S,
        TRANS_S,
        DISCARD_S,
        GAP_S
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [7:0]     r_word_cnt;
    logic [7:0]     w_word_cnt_nxt;
    logic [7:0]     r_gap_cnt;
    logic [7:0]     w_gap_cnt_nxt;

    logic [1:0]     w_tag;
    logic           w_fwd;
    logic           w_force_tail;
    logic           w_err;
    logic           w_pkt_done;
    logic [133:0]   w_fwd_data;

    assign w_tag = iv_fifo_rdata[133:132];

    always_comb begin
        w_state_nxt    = r_state;
        w_word_cnt_nxt = r_word_cnt;
        w_gap_cnt_nxt  = '0;
        o_fifo_rd      = 1'b0;
        w_fwd          = 1'b0;
        w_force_tail   = 1'b0;
        w_err          = 1'b0;
        w_pkt_done     = 1'b0;

        case (r_state)
            IDLE_S: begin
                if (!i_fifo_empty) begin
                    if (w_tag == TAG_HEAD) begin
                        if (i_port_ready) begin
                            o_fifo_rd      = 1'b1;
                            w_fwd          = 1'b1;
                            w_word_cnt_nxt = 8'd1;
                            w_state_nxt    = TRANS_S;
                        end
                    end else begin
                        // Stray body/tail outside a packet: drop it to resync.
                        o_fifo_rd = 1'b1;
                        w_err     = 1'b1;
                    end
                end
            end

            TRANS_S: begin
                if (!i_fifo_empty) begin
                    if (w_tag == TAG_TAIL) begin
                        o_fifo_rd   = 1'b1;
                        w_fwd       = 1'b1;
                        w_pkt_done  = 1'b1;
                        w_state_nxt = GAP_S;
                    end else if (w_tag == TAG_HEAD) begin
                        // Truncated packet: leave the new head for the next packet.
                        w_err       = 1'b1;
                        w_state_nxt = GAP_S;
                    end else if (r_word_cnt == LP_LAST_WORD) begin
                        // Length limit reached: close the packet with a forced tail.
                        o_fifo_rd    = 1'b1;
                        w_fwd        = 1'b1;
                        w_force_tail = 1'b1;
                        w_err        = 1'b1;
                        w_state_nxt  = DISCARD_S;
                    end else begin
                        o_fifo_rd      = 1'b1;
                        w_fwd          = 1'b1;
                        w_word_cnt_nxt = r_word_cnt + 8'd1;
                    end
                end
            end

            DISCARD_S: begin
                if (!i_fifo_empty) begin
                    if (w_tag == TAG_HEAD) begin
                        w_state_nxt = GAP_S;
                    end else begin
                        o_fifo_rd = 1'b1;
                        if (w_tag == TAG_TAIL) begin
                            w_state_nxt = GAP_S;
                        end
                    end
                end
            end

            GAP_S: begin
                // Gap counter is 0 on the first GAP_S cycle, so GAP_S lasts
                // exactly IFG_CYCLES cycles.
                if (r_gap_cnt == LP_GAP_LAST) begin
                    w_state_nxt = IDLE_S;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 8'd1;
                end
            end

            default: begin
                w_state_nxt = IDLE_S;
            end
        endcase
    end

    assign w_fwd_data = w_force_tail ? {TAG_TAIL, iv_fifo_rdata[131:0]} : iv_fifo_rdata;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE_S;
            r_word_cnt  <= '0;
            r_gap_cnt   <= '0;
            ov_data     <= '0;
            o_data_wr   <= 1'b0;
            ov_pkt_cnt  <= '0;
            o_err_pulse <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_word_cnt  <= w_word_cnt_nxt;
            r_gap_cnt   <= w_gap_cnt_nxt;
            ov_data     <= w_fwd ? w_fwd_data : '0;
            o_data_wr   <= w_fwd;
            o_err_pulse <= w_err;
            if (w_pkt_done) begin
                ov_pkt_cnt <= ov_pkt_cnt + 16'd1;
            end
        end
    end

endmodule

// File: doc/tsmp_fifo_read_scheduler.md
Name: tsmp_fifo_read_scheduler

Overview:
- Drains the 512-deep, 134-bit TSMP packet FIFO filled by the 2-to-1 packet mux and sequences whole packets toward the host-facing transmit port.
- Starts a packet only when downstream is ready.
- Enforces a minimum inter-packet gap.
- Resynchronises on malformed framing, truncates over-length packets, and keeps a sent-packet counter.

Parameters:
- IFG_CYCLES, 12, idle cycles inserted after each packet tail before the next head may be read (1..255).
- MAX_PKT_CYCLES, 128, maximum words per packet, including head and tail (2..255).

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  asynchronous active-low reset.
- iv_fifo_rdata  input  134  show-ahead FIFO head word; [133:132] is 01 for head, 10 for tail, 11 for body; [131:0] is payload.
- i_fifo_empty  input  1  FIFO empty flag.
- o_fifo_rd  output  1  FIFO pop; combinational from state and inputs.
- i_port_ready  input  1  downstream can accept a full packet; sampled only at packet start.
- ov_data  output  134  packet word to transmit port.
- o_data_wr  output  1  ov_data valid.
- ov_pkt_cnt  output  16  packets completed with a tail, wraps.
- o_err_pulse  output  1  one-cycle pulse per framing or length error.

Behaviour:
- Reset: one clock, i_clk; reset is asynchronous and active-low on i_rst_n.
  - Outputs clear: ov_data=0, o_data_wr=0, ov_pkt_cnt=0, o_err_pulse=0.
  - State goes to IDLE_S; word and gap counters go to 0.
  - Reset mid-packet abandons the packet; no tail is emitted.
- o_fifo_rd is never asserted while i_fifo_empty=1.
- Output timing: every popped word that is forwarded appears on ov_data with o_data_wr=1 exactly one cycle after the pop cycle. Latency is 1.
- o_data_wr=0 in every cycle without a forwarded pop, and ov_data is then 0.
- IDLE_S, when !i_fifo_empty:
  - head tag 01 and i_port_ready=1: pop, forward, word_cnt=1, go to TRANS_S.
  - head tag 01 and i_port_ready=0: no pop, stay.
  - head tag not 01 (stray body or tail): pop without forwarding, o_err_pulse=1 next cycle, stay. This is resync.
- TRANS_S, when !i_fifo_empty (an empty FIFO stalls with no pop, no write, no timeout):
  - tag 10: pop, forward, ov_pkt_cnt+1 (registered with the forwarded tail), go to GAP_S.
  - tag 01 (unexpected head, truncated packet): no pop, nothing forwarded, o_err_pulse=1, go to GAP_S. The head stays in the FIFO for the next packet.
  - tag 11 with word_cnt = MAX_PKT_CYCLES-1: pop and forward with [133:132] forced to 10, o_err_pulse=1, go to DISCARD_S. ov_pkt_cnt does not increment.
  - otherwise: pop, forward, word_cnt+1.
- DISCARD_S: pop every available word without forwarding until a word tagged 10 is popped, then go to GAP_S. A word tagged 01 is not popped; go to GAP_S.
- GAP_S: no pops for IFG_CYCLES cycles, counted from the cycle after entry, then go to IDLE_S. The first possible head pop is at entry+IFG_CYCLES+1.
- Simultaneous conditions:
  - A framing error and a length error cannot coincide; one pulse per event.
  - ov_pkt_cnt 16'hFFFF+1 wraps to 0.
- i_port_ready changes after the head pop do not affect the packet in flight.

Test Plan:
- Single 4-word packet (01,11,11,10) in FIFO, ready=1 → o_fifo_rd high for 4 consecutive cycles; o_data_wr high cycles 1–4 after the first pop with identical data; ov_pkt_cnt=1; no err.
- Two back-to-back 2-word packets, IFG_CYCLES=12 → second head popped exactly 13 cycles after the first tail pop; ov_pkt_cnt=2.
- Head present, i_port_ready=0 for 20 cycles then 1 → no pop for 20 cycles; pop on the first cycle with ready=1.
- FIFO sequence 11,10,01,10 in IDLE_S → two err pulses, no output for the stray words; then a 2-word packet is forwarded; ov_pkt_cnt=1.
- 130-word packet with MAX_PKT_CYCLES=128 → 128 words output, word 128 tagged 10; one err pulse; remaining 2 words popped but not forwarded; ov_pkt_cnt=0.
- Mid-packet FIFO empty for 5 cycles → output pauses 5 cycles and resumes; packet intact. Assert reset mid-packet → all outputs 0 immediately; next packet starts cleanly from IDLE_S.
